alu_core: RTL and testbench

Registered 8-bit arithmetic/logic unit for the datapath execute stage. Each cycle it samples two operands and a 2-bit operation select, computes AND, OR, ADD or SUB, and registers the result with zero, negative, carry and overflow flags. Results are available one clock after the operands are sampled. A valid strobe travels alongside the data so that downstream stages know which results are meaningful.

---
 rtl/alu_core.sv | 97 +++++++++
 tb/tb_alu_core.sv | 98 +++++++++
 2 files changed

// File: rtl/alu_core.sv
// Registered ALU for the execute stage: AND/OR/ADD/SUB with zero, negative,
// carry and overflow flags, one cycle of latency, valid strobe alongside.
module alu_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InValid,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [1:0]       ALUControl,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             OutValid
);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  // SUB reuses the adder as A + ~B + 1, so carry-out doubles as not-borrow.
  function automatic logic [WIDTH:0] add_carry(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             cin);
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  endfunction

  // Signed overflow: operands (after B inversion) agree in sign, result does not.
  function automatic logic signed_ovf(input logic signed [WIDTH-1:0] a,
                                      input logic signed [WIDTH-1:0] b,
                                      input logic signed [WIDTH-1:0] r);
    return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  logic                    w_is_sub_p0;
  logic        [WIDTH-1:0] w_b_p0;
  logic        [WIDTH:0]   w_sum_p0;
  logic signed [WIDTH-1:0] w_result_p0;
  logic                    w_carry_p0;
  logic                    w_ovf_p0;

  always_comb begin
    w_is_sub_p0 = (ALUControl == OP_SUB);
    w_b_p0      = w_is_sub_p0 ? ~SrcB : SrcB;
    w_sum_p0    = add_carry(SrcA, w_b_p0, w_is_sub_p0);
    w_result_p0 = '0;
    w_carry_p0  = 1'b0;
    w_ovf_p0    = 1'b0;
    case (ALUControl)
      OP_AND: w_result_p0 = SrcA & SrcB;
      OP_OR:  w_result_p0 = SrcA | SrcB;
      OP_ADD, OP_SUB: begin
        w_result_p0 = w_sum_p0[WIDTH-1:0];
        w_carry_p0  = w_sum_p0[WIDTH];
        w_ovf_p0    = signed_ovf(SrcA, w_b_p0, w_sum_p0[WIDTH-1:0]);
      end
      default: w_result_p0 = '0;
    endcase
  end

  // p0 -> p1: output register stage
  logic signed [WIDTH-1:0] r_result_p1;
  logic                    r_zero_p1;
  logic                    r_carry_p1;
  logic                    r_ovf_p1;
  logic                    r_vld_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result_p1 <= '0;
      r_zero_p1   <= 1'b1;
      r_carry_p1  <= 1'b0;
      r_ovf_p1    <= 1'b0;
      r_vld_p1    <= 1'b0;
    end else begin
      r_vld_p1 <= InValid;
      if (InValid) begin
        r_result_p1 <= w_result_p0;
        r_zero_p1   <= (w_result_p0 == '0);
        r_carry_p1  <= w_carry_p0;
        r_ovf_p1    <= w_ovf_p0;
      end
    end
  end

  assign ALUResult = r_result_p1;
  assign Zero      = r_zero_p1;
  assign Negative  = r_result_p1[WIDTH-1];
  assign Carry     = r_carry_p1;
  assign Overflow  = r_ovf_p1;
  assign OutValid  = r_vld_p1;

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core: hand-computed vectors for each operation,
// flag edge cases, hold behaviour and reset priority.
module tb_alu_core;

  logic       clk = 1'b0;
  logic       reset;
  logic       InValid;
  logic [7:0] SrcA;
  logic [7:0] SrcB;
  logic [1:0] ALUControl;
  logic [7:0] ALUResult;
  logic       Zero, Negative, Carry, Overflow, OutValid;

  int tests = 0;
  int fails = 0;

  alu_core #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .InValid(InValid),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .ALUResult(ALUResult), .Zero(Zero), .Negative(Negative),
    .Carry(Carry), .Overflow(Overflow), .OutValid(OutValid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs away from the edge, then sample just after the next rising edge.
  task automatic step(input logic rst, input logic vld, input logic [7:0] a,
                      input logic [7:0] b, input logic [1:0] ctl);
    @(negedge clk);
    reset = rst; InValid = vld; SrcA = a; SrcB = b; ALUControl = ctl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] res, input logic z,
                         input logic n, input logic c, input logic v, input logic ov);
    chk({tag, ".res"}, {24'd0, ALUResult}, {24'd0, res});
    chk({tag, ".Z"},   {31'd0, Zero},      {31'd0, z});
    chk({tag, ".N"},   {31'd0, Negative},  {31'd0, n});
    chk({tag, ".C"},   {31'd0, Carry},     {31'd0, c});
    chk({tag, ".V"},   {31'd0, Overflow},  {31'd0, v});
    chk({tag, ".vld"}, {31'd0, OutValid},  {31'd0, ov});
  endtask

  initial begin
    reset = 1'b1; InValid = 1'b0; SrcA = '0; SrcB = '0; ALUControl = 2'b00;
    step(1'b1, 1'b0, 8'h00, 8'h00, 2'b00);
    step(1'b1, 1'b1, 8'h12, 8'h34, 2'b10);
    chk_all("reset", 8'h00, 1, 0, 0, 0, 0);

    // res, Z, N, C, V, OutValid
    step(0, 1, 8'b00000011, 8'b10000001, 2'b00); chk_all("and",     8'h01, 0, 0, 0, 0, 1);
    step(0, 1, 8'b10101010, 8'b01010101, 2'b01); chk_all("or",      8'hFF, 0, 1, 0, 0, 1);
    step(0, 1, 8'd10,  8'd100, 2'b10);           chk_all("add_small", 8'h6E, 0, 0, 0, 0, 1);
    step(0, 1, 8'd200, 8'd100, 2'b10);           chk_all("add_carry", 8'h2C, 0, 0, 1, 0, 1);
    step(0, 1, 8'hF0, 8'h0F, 2'b00);             chk_all("and_zero",  8'h00, 1, 0, 0, 0, 1);
    step(0, 1, 8'h7F, 8'h01, 2'b10);             chk_all("add_ovf",   8'h80, 0, 1, 0, 1, 1);
    step(0, 1, 8'hFF, 8'h01, 2'b10);             chk_all("add_wrap",  8'h00, 1, 0, 1, 0, 1);
    step(0, 1, 8'd100, 8'd76, 2'b11);            chk_all("sub",       8'h18, 0, 0, 1, 0, 1);
    step(0, 1, 8'd5, 8'd5, 2'b11);               chk_all("sub_eq",    8'h00, 1, 0, 1, 0, 1);
    step(0, 1, 8'd3, 8'd5, 2'b11);               chk_all("sub_borrow", 8'hFE, 0, 1, 0, 0, 1);
    step(0, 1, 8'h80, 8'h01, 2'b11);             chk_all("sub_ovf",   8'h7F, 0, 0, 1, 1, 1);
    step(0, 1, 8'h00, 8'h00, 2'b11);             chk_all("sub_zero",  8'h00, 1, 0, 1, 0, 1);
    step(0, 1, 8'h01, 8'h7F, 2'b11);             chk_all("sub_neg",   8'h82, 0, 1, 0, 0, 1);
    step(0, 1, 8'h80, 8'h80, 2'b10);             chk_all("add_negovf", 8'h00, 1, 0, 1, 1, 1);

    // Hold: one valid ADD followed by idle cycles with changing operands
    step(0, 1, 8'd7, 8'd9, 2'b10);               chk_all("hold0", 8'h10, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'hFF - 8'(i), 8'h01 + 8'(i), 2'(i));
      chk_all($sformatf("hold%0d", i + 1), 8'h10, 0, 0, 0, 0, 0);
    end

    // Reset takes priority over a valid op on the same edge
    step(0, 1, 8'h80, 8'h7F, 2'b01);             chk_all("pre_rst", 8'hFF, 0, 1, 0, 0, 1);
    step(1, 1, 8'h7F, 8'h01, 2'b10);             chk_all("rst_prio", 8'h00, 1, 0, 0, 0, 0);
    step(0, 1, 8'd200, 8'd100, 2'b10);           chk_all("post_rst", 8'h2C, 0, 0, 1, 0, 1);
    step(0, 0, 8'h00, 8'h00, 2'b00);             chk_all("post_idle", 8'h2C, 0, 0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
